// File: rtl/cheri_trvk_issuer.sv
// Tracks outstanding capability loads (CLC) in order. It issues a tag
// reservation when a load is accepted, and a registered tag revocation or
// release request when the revocation-lookup response for the oldest load
// arrives.
module cheri_trvk_issuer #(
  parameter int Depth     = 2,
  parameter bit ErrClrTag = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clc_req_i,
  input  logic [4:0] clc_rd_addr_i,
  output logic       clc_stall_o,
  input  logic       rvk_valid_i,
  input  logic       rvk_revoked_i,
  input  logic       rvk_err_i,
  output logic       trsv_en_o,
  output logic [4:0] trsv_addr_o,
  output logic [6:0] trsv_par_o,
  output logic       trvk_en_o,
  output logic       trvk_clrtag_o,
  output logic [4:0] trvk_addr_o,
  output logic [6:0] trvk_par_o,
  output logic       busy_o,
  output logic       alert_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  // Check bits of the inverted SECDED(39,32) code. The inversion makes an
  // all-zero word encode to a non-zero check field.
  function automatic logic [6:0] secded_inv_chk(input logic [31:0] d);
    logic [38:0] w;
    logic [6:0]  c;
    w    = {7'h0, d};
    c[0] = ^(w & 39'h002606BD25);
    c[1] = ^(w & 39'h00DEBA8050);
    c[2] = ^(w & 39'h00413D89AA);
    c[3] = ^(w & 39'h0031234ED1);
    c[4] = ^(w & 39'h00C2C1323B);
    c[5] = ^(w & 39'h002DCC624C);
    c[6] = ^(w & 39'h0098505586);
    return c ^ 7'h2a;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic [4:0]      entry_reg [Depth];
  logic            alert_reg, alert_next;
  logic            trvk_en_reg, trvk_en_next;
  logic            trvk_clrtag_reg, trvk_clrtag_next;
  logic [4:0]      trvk_addr_reg, trvk_addr_next;
  logic [6:0]      trvk_par_reg, trvk_par_next;
  logic            push, pop, spurious;
  logic [4:0]      head_addr;

  // A pending response frees a slot in the same cycle, so a full tracker
  // only stalls when no response is arriving.
  assign clc_stall_o = (cnt_reg == DepthCnt) && !rvk_valid_i;
  // x0 never holds a capability, so loads to it need no tracking.
  assign push        = rst_ni && clc_req_i && !clc_stall_o && (clc_rd_addr_i != 5'd0);
  assign pop         = rvk_valid_i && (cnt_reg != '0);
  assign spurious    = rvk_valid_i && (cnt_reg == '0);
  assign head_addr   = entry_reg[rd_ptr_reg];

  assign trsv_en_o   = push;
  assign trsv_addr_o = push ? clc_rd_addr_i : 5'd0;
  assign trsv_par_o  = secded_inv_chk({26'h0, trsv_en_o, trsv_addr_o});

  assign trvk_en_o     = trvk_en_reg;
  assign trvk_clrtag_o = trvk_clrtag_reg;
  assign trvk_addr_o   = trvk_addr_reg;
  assign trvk_par_o    = trvk_par_reg;
  assign busy_o        = (cnt_reg != '0);
  assign alert_o       = alert_reg;

  // Next-state for pointers, occupancy, alert and the revocation request.
  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    cnt_next         = cnt_reg;
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    if (push && !pop) cnt_next = cnt_reg + CntW'(1);
    if (pop && !push) cnt_next = cnt_reg - CntW'(1);
    alert_next       = alert_reg || spurious || (cnt_reg > DepthCnt);
    trvk_en_next     = pop;
    trvk_clrtag_next = pop && (rvk_revoked_i || (rvk_err_i && ErrClrTag));
    trvk_addr_next   = pop ? head_addr : 5'd0;
    trvk_par_next    = secded_inv_chk({25'h0, trvk_en_next, trvk_clrtag_next, trvk_addr_next});
  end

  // Control and output state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      cnt_reg         <= '0;
      alert_reg       <= 1'b0;
      trvk_en_reg     <= 1'b0;
      trvk_clrtag_reg <= 1'b0;
      trvk_addr_reg   <= 5'd0;
      trvk_par_reg    <= 7'h2a;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      cnt_reg         <= cnt_next;
      alert_reg       <= alert_next;
      trvk_en_reg     <= trvk_en_next;
      trvk_clrtag_reg <= trvk_clrtag_next;
      trvk_addr_reg   <= trvk_addr_next;
      trvk_par_reg    <= trvk_par_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < Depth; gi++) begin : g_entry
      // Each slot captures the destination address when the write pointer selects it.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          entry_reg[gi] <= 5'd0;
        end else if (push && (wr_ptr_reg == PtrW'(gi))) begin
          entry_reg[gi] <= clc_rd_addr_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cheri_trvk_issuer.sv
// Randomised and directed bench for cheri_trvk_issuer. Two instances
// (Depth=2/ErrClrTag=1 and Depth=3/ErrClrTag=0) share the same stimulus.
// Each instance is checked against a queue-based reference model.
module tb_cheri_trvk_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req, vld, rev, err;
  logic [4:0] addr;

  logic       stall [2], trsv_en [2], trvk_en [2], trvk_clr [2], busy [2], alert [2];
  logic [4:0] trsv_addr [2], trvk_addr [2];
  logic [6:0] trsv_par [2], trvk_par [2];

  cheri_trvk_issuer #(.Depth(2), .ErrClrTag(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clc_req_i(req), .clc_rd_addr_i(addr),
    .clc_stall_o(stall[0]), .rvk_valid_i(vld), .rvk_revoked_i(rev), .rvk_err_i(err),
    .trsv_en_o(trsv_en[0]), .trsv_addr_o(trsv_addr[0]), .trsv_par_o(trsv_par[0]),
    .trvk_en_o(trvk_en[0]), .trvk_clrtag_o(trvk_clr[0]), .trvk_addr_o(trvk_addr[0]),
    .trvk_par_o(trvk_par[0]), .busy_o(busy[0]), .alert_o(alert[0])
  );

  cheri_trvk_issuer #(.Depth(3), .ErrClrTag(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clc_req_i(req), .clc_rd_addr_i(addr),
    .clc_stall_o(stall[1]), .rvk_valid_i(vld), .rvk_revoked_i(rev), .rvk_err_i(err),
    .trsv_en_o(trsv_en[1]), .trsv_addr_o(trsv_addr[1]), .trsv_par_o(trsv_par[1]),
    .trvk_en_o(trvk_en[1]), .trvk_clrtag_o(trvk_clr[1]), .trvk_addr_o(trvk_addr[1]),
    .trvk_par_o(trvk_par[1]), .busy_o(busy[1]), .alert_o(alert[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: outstanding loads in order, plus the expected registered outputs.
  logic [4:0] mq [2][$];
  bit         m_en [2], m_clr [2], m_alert [2];
  logic [4:0] m_addr [2];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit eclr(input int k);
    return (k == 0);
  endfunction

  // Each check bit is the parity of the data bits its mask selects, then the result is inverted by 0x2a.
  function automatic logic [6:0] ref_par(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  r;
    m[0] = 32'h2606BD25; m[1] = 32'hDEBA8050; m[2] = 32'h413D89AA;
    m[3] = 32'h31234ED1; m[4] = 32'hC2C1323B; m[5] = 32'h2DCC624C;
    m[6] = 32'h98505586;
    for (int i = 0; i < 7; i++) begin
      r[i] = 1'b0;
      for (int j = 0; j < 32; j++) if (m[i][j]) r[i] = r[i] ^ d[j];
    end
    return r ^ 7'h2a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, check both instances, then advance the model.
  task automatic step(input bit r, input bit q, input logic [4:0] a,
                      input bit v, input bit rv, input bit e);
    bit       push_k [2];
    bit       exp_stall;
    bit       pop;
    string    s;
    rst_n = r; req = q; addr = a; vld = v; rev = rv; err = e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s = $sformatf("d%0d", k);
      exp_stall = (mq[k].size() == dep(k)) && !v;
      push_k[k] = r && q && !exp_stall && (a != 5'd0);
      check({s, ".stall"},     32'(stall[k]),     32'(exp_stall));
      check({s, ".trsv_en"},   32'(trsv_en[k]),   32'(push_k[k]));
      check({s, ".trsv_addr"}, 32'(trsv_addr[k]), 32'(push_k[k] ? a : 5'd0));
      check({s, ".trsv_par"},  32'(trsv_par[k]),
            32'(ref_par({26'h0, push_k[k], (push_k[k] ? a : 5'd0)})));
      check({s, ".trvk_en"},   32'(trvk_en[k]),   32'(m_en[k]));
      check({s, ".trvk_clr"},  32'(trvk_clr[k]),  32'(m_clr[k]));
      check({s, ".trvk_addr"}, 32'(trvk_addr[k]), 32'(m_addr[k]));
      check({s, ".trvk_par"},  32'(trvk_par[k]),
            32'(ref_par({25'h0, m_en[k], m_clr[k], m_addr[k]})));
      check({s, ".busy"},      32'(busy[k]),      32'(mq[k].size() != 0));
      check({s, ".alert"},     32'(alert[k]),     32'(m_alert[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        mq[k].delete();
        m_en[k] = 0; m_clr[k] = 0; m_addr[k] = 5'd0; m_alert[k] = 0;
      end else begin
        pop = v && (mq[k].size() != 0);
        if (v && mq[k].size() == 0) m_alert[k] = 1;
        if (pop) begin
          m_addr[k] = mq[k].pop_front();
          m_en[k]   = 1;
          m_clr[k]  = rv | (e & eclr(k));
        end else begin
          m_en[k] = 0; m_clr[k] = 0; m_addr[k] = 5'd0;
        end
        if (push_k[k]) mq[k].push_back(a);
      end
    end
    $display("cyc %0d rst_n=%b req=%b addr=%0d vld=%b rev=%b err=%b | outstanding %0d/%0d",
             cyc, r, q, a, v, rv, e, mq[0].size(), mq[1].size());
    cyc++;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_en[k] = 0; m_clr[k] = 0; m_addr[k] = 5'd0; m_alert[k] = 0;
    end
    rst_n = 1'b0; req = 1'b0; addr = 5'd0; vld = 1'b0; rev = 1'b0; err = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 5'd6, 0, 0, 0);   // request during reset must not reserve
    step(0, 0, 5'd0, 0, 0, 0);
    // Single load then revoked response
    step(1, 1, 5'd10, 0, 0, 0);
    step(1, 0, 5'd0, 1, 1, 0);
    step(1, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 0, 0, 0);
    // Fill, reject when full, drain in order, then a spurious response
    step(1, 1, 5'd3, 0, 0, 0);
    step(1, 1, 5'd4, 0, 0, 0);
    step(1, 1, 5'd5, 0, 0, 0);
    step(1, 0, 5'd0, 1, 0, 0);
    step(1, 0, 5'd0, 1, 1, 0);
    step(1, 0, 5'd0, 1, 0, 0);
    step(1, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    // Full, then a push and a pop in the same cycle
    step(1, 1, 5'd3, 0, 0, 0);
    step(1, 1, 5'd4, 0, 0, 0);
    step(1, 1, 5'd7, 1, 0, 0);
    // Load to x0, then a bus-error response
    step(1, 1, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 1, 0, 1);
    // Reset while loads are outstanding
    step(1, 1, 5'd9, 0, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 0, 0, 0);
    step(1, 0, 5'd0, 0, 0, 0);
    // A spurious response on an empty tracker leaves alert set until reset
    step(1, 0, 5'd0, 1, 0, 0);
    step(1, 1, 5'd12, 0, 0, 0);
    step(1, 0, 5'd0, 1, 0, 1);
    step(1, 0, 5'd0, 0, 0, 0);
    step(0, 0, 5'd0, 0, 0, 0);
    // Random traffic, with repeated addresses and an occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) != 0, ($urandom % 10) < 6, 5'($urandom % 8),
           ($urandom % 10) < 4, 1'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
